// File: rtl/ddr_read_prefetch_if.sv
// Single-word read handshake between the framebuffer prefetcher and the Ddr controller.
interface ddr_read_prefetch_if;
    logic        read;
    logic [23:0] readAddress;
    logic        readAcknowledge;
    logic [15:0] readData;

    modport master (
        output read,
        output readAddress,
        input  readAcknowledge,
        input  readData
    );

    modport slave (
        input  read,
        input  readAddress,
        output readAcknowledge,
        output readData
    );
endinterface

// File: rtl/ddr_read_prefetch.sv
// Framebuffer read prefetcher: walks FRAME_WORDS words from BASE_ADDR into a small FIFO for the pixel path.
// Optional build macro PREFETCH_WATERMARK_EN adds full/half-full hysteresis to group reads into bursts.
module ddr_read_prefetch #(
    parameter int unsigned FIFO_DEPTH  = 16,
    parameter int unsigned LEVEL_W     = 5,
    parameter logic [23:0] BASE_ADDR   = 24'h000000,
    parameter int unsigned FRAME_WORDS = 307200
) (
    input  logic               clk133_p,
    input  logic               rst,
    input  logic               frameStart,
    input  logic               pixelRequest,
    output logic [15:0]        pixelData,
    output logic               pixelValid,
    output logic               underflow,
    output logic [LEVEL_W-1:0] fifoLevel,
    ddr_read_prefetch_if.master ddr
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = $clog2(FRAME_WORDS + 1);
    localparam logic [LEVEL_W-1:0] FULL_LVL  = LEVEL_W'(FIFO_DEPTH);
    localparam logic [CNT_W-1:0]   LAST_WORD = CNT_W'(FRAME_WORDS - 1);
    localparam logic [CNT_W-1:0]   FRAME_CNT = CNT_W'(FRAME_WORDS);

    typedef enum logic [1:0] {IDLE, FETCH, DONE} state_t;

    state_t             state_q, state_d;
    logic               read_q, read_d;
    logic [23:0]        addr_q, addr_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [PTR_W-1:0]   wptr_q, wptr_d;
    logic [PTR_W-1:0]   rptr_q, rptr_d;
    logic [LEVEL_W-1:0] level_q, level_d;
    logic [15:0]        pix_data_q, pix_data_d;
    logic               pix_vld_q, pix_vld_d;
    logic               uflow_q, uflow_d;
    logic               pend_q, pend_d;
    logic               hold_d;
    logic [15:0]        mem_q [FIFO_DEPTH];

    logic outstanding, ack, restart, pix_flush, push, pop;

`ifdef PREFETCH_WATERMARK_EN
    localparam logic [LEVEL_W-1:0] HALF_LVL = LEVEL_W'(FIFO_DEPTH / 2);
    logic hold_q;
`endif

    // A restart never cancels an in-flight read; it waits for that ack and drops its data.
    assign outstanding = read_q && !ddr.readAcknowledge;
    assign ack         = read_q && ddr.readAcknowledge;
    assign restart     = (frameStart || pend_q) && !outstanding;
    assign pix_flush   = frameStart || restart;
    assign pop         = pixelRequest && !pix_flush && (level_q != '0);
    assign push        = ack && !restart;

    always_comb begin
        state_d    = state_q;
        addr_d     = addr_q;
        cnt_d      = cnt_q;
        wptr_d     = wptr_q;
        rptr_d     = rptr_q;
        level_d    = level_q + LEVEL_W'(push) - LEVEL_W'(pop);
        pix_data_d = pix_data_q;
        pix_vld_d  = pixelRequest;
        uflow_d    = uflow_q;
        pend_d     = pend_q;
        read_d     = 1'b0;

        if (frameStart && outstanding)
            pend_d = 1'b1;

        if (pixelRequest) begin
            pix_data_d = pop ? mem_q[rptr_q] : '0;
            if (!pix_flush && level_q == '0)
                uflow_d = 1'b1;
        end
        if (pop)
            rptr_d = rptr_q + PTR_W'(1);

        if (push) begin
            wptr_d = wptr_q + PTR_W'(1);
            addr_d = addr_q + 24'd1;
            cnt_d  = cnt_q + CNT_W'(1);
            if (cnt_q == LAST_WORD)
                state_d = DONE;
        end

        if (restart) begin
            state_d = FETCH;
            addr_d  = BASE_ADDR;
            cnt_d   = '0;
            wptr_d  = '0;
            rptr_d  = '0;
            level_d = '0;
            uflow_d = 1'b0;
            pend_d  = 1'b0;
        end

`ifdef PREFETCH_WATERMARK_EN
        hold_d = hold_q;
        if (level_d == FULL_LVL)
            hold_d = 1'b1;
        else if (level_d <= HALF_LVL)
            hold_d = 1'b0;
`else
        hold_d = 1'b0;
`endif

        // Request decision uses next-cycle level so read never runs ahead of free space.
        if (outstanding)
            read_d = 1'b1;
        else
            read_d = (state_d == FETCH) && (level_d < FULL_LVL) &&
                     (cnt_d < FRAME_CNT) && !hold_d;
    end

    always_ff @(posedge clk133_p) begin
        if (rst) begin
            state_q    <= IDLE;
            read_q     <= 1'b0;
            addr_q     <= BASE_ADDR;
            cnt_q      <= '0;
            wptr_q     <= '0;
            rptr_q     <= '0;
            level_q    <= '0;
            pix_data_q <= '0;
            pix_vld_q  <= 1'b0;
            uflow_q    <= 1'b0;
            pend_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            read_q     <= read_d;
            addr_q     <= addr_d;
            cnt_q      <= cnt_d;
            wptr_q     <= wptr_d;
            rptr_q     <= rptr_d;
            level_q    <= level_d;
            pix_data_q <= pix_data_d;
            pix_vld_q  <= pix_vld_d;
            uflow_q    <= uflow_d;
            pend_q     <= pend_d;
        end
    end

`ifdef PREFETCH_WATERMARK_EN
    always_ff @(posedge clk133_p) begin
        if (rst)
            hold_q <= 1'b0;
        else
            hold_q <= hold_d;
    end
`endif

    always_ff @(posedge clk133_p) begin
        if (push)
            mem_q[wptr_q] <= ddr.readData;
    end

    assign ddr.read        = read_q;
    assign ddr.readAddress = addr_q;
    assign pixelData       = pix_data_q;
    assign pixelValid      = pix_vld_q;
    assign underflow       = uflow_q;
    assign fifoLevel       = level_q;

    a_read_stable: assert property (@(posedge clk133_p) disable iff (rst)
        outstanding |=> read_q && $stable(addr_q));
    a_level_bound: assert property (@(posedge clk133_p) disable iff (rst)
        level_q <= FULL_LVL);
    a_no_overfill: assert property (@(posedge clk133_p) disable iff (rst)
        read_q |-> level_q < FULL_LVL);

endmodule

// File: tb/tb_ddr_read_prefetch.sv
// Randomized bench for ddr_read_prefetch with a queue-based reference model and a latency-controlled Ddr model.
module tb_ddr_read_prefetch;

    localparam int          FW    = 20;
    localparam int          DEPTH = 16;
    localparam logic [23:0] BASE  = 24'h000000;

    logic        clk = 1'b0;
    logic        rst;
    logic        frameStart;
    logic        pixelRequest;
    logic [15:0] pixelData;
    logic        pixelValid;
    logic        underflow;
    logic [4:0]  fifoLevel;

    ddr_read_prefetch_if bus ();

    ddr_read_prefetch #(
        .FIFO_DEPTH (DEPTH),
        .LEVEL_W    (5),
        .BASE_ADDR  (BASE),
        .FRAME_WORDS(FW)
    ) dut (
        .clk133_p    (clk),
        .rst         (rst),
        .frameStart  (frameStart),
        .pixelRequest(pixelRequest),
        .pixelData   (pixelData),
        .pixelValid  (pixelValid),
        .underflow   (underflow),
        .fifoLevel   (fifoLevel),
        .ddr         (bus)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    // Reference model: FIFO contents, next fetch address, fetched-word count, pending restart.
    logic [15:0] m_q[$];
    logic [23:0] m_addr;
    int          m_words;
    bit          m_fetching;
    bit          m_pend;
    bit          m_read;
    bit          m_uf;
    bit          m_hold;
    int          lat;
    int          age;
    int          delivered;

    task automatic cycle(input bit fs, input bit preq);
        bit          ack, outstanding, restart, pre_read;
        logic [15:0] exp_pix;
        outstanding = m_read;
        pre_read    = bus.read;
        ack         = bus.read && (age >= lat);
        frameStart          = fs;
        pixelRequest        = preq;
        bus.readAcknowledge = ack;
        bus.readData        = ack ? bus.readAddress[15:0] : 16'($urandom);

        restart = (fs || m_pend) && !(outstanding && !ack);
        if (fs && outstanding && !ack) m_pend = 1'b1;
        exp_pix = 16'h0000;
        if (preq && !(fs || restart)) begin
            if (m_q.size() > 0) begin
                exp_pix = m_q.pop_front();
                delivered++;
            end else begin
                m_uf = 1'b1;
            end
        end
        if (ack && !restart) begin
            m_q.push_back(m_addr[15:0]);
            m_addr = m_addr + 24'd1;
            m_words++;
        end
        if (restart) begin
            m_q.delete();
            m_addr = BASE;
            m_words = 0;
            m_uf = 1'b0;
            m_pend = 1'b0;
            m_fetching = 1'b1;
            m_hold = 1'b0;
        end
        if (m_words >= FW) m_fetching = 1'b0;
`ifdef PREFETCH_WATERMARK_EN
        if (m_q.size() == DEPTH) m_hold = 1'b1;
        else if (m_q.size() <= DEPTH / 2) m_hold = 1'b0;
`endif
        m_read = (outstanding && !ack) || (m_fetching && m_q.size() < DEPTH && !m_hold);

        @(posedge clk);
        #1;
        if (ack) age = 0;
        else if (pre_read) age++;
        frameStart = 1'b0;
        pixelRequest = 1'b0;
        bus.readAcknowledge = 1'b0;

        checks++;
        if (bus.read !== m_read) begin
            errors++;
            $display("FAIL read_req t=%0t got=%b want=%b", $time, bus.read, m_read);
        end
        if (m_read) begin
            checks++;
            if (bus.readAddress !== m_addr) begin
                errors++;
                $display("FAIL read_addr t=%0t got=%h want=%h", $time, bus.readAddress, m_addr);
            end
        end
        checks++;
        if (pixelValid !== preq) begin
            errors++;
            $display("FAIL pixel_valid t=%0t got=%b want=%b", $time, pixelValid, preq);
        end
        if (preq) begin
            checks++;
            if (pixelData !== exp_pix) begin
                errors++;
                $display("FAIL pixel_data t=%0t got=%h want=%h", $time, pixelData, exp_pix);
            end
        end
        checks++;
        if (underflow !== m_uf) begin
            errors++;
            $display("FAIL underflow t=%0t got=%b want=%b", $time, underflow, m_uf);
        end
        checks++;
        if (fifoLevel !== 5'(m_q.size())) begin
            errors++;
            $display("FAIL fifo_level t=%0t got=%0d want=%0d", $time, fifoLevel, m_q.size());
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        frameStart = 1'b0;
        pixelRequest = 1'b0;
        bus.readAcknowledge = 1'b0;
        bus.readData = 16'h0;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (bus.read !== 1'b0 || bus.readAddress !== BASE || pixelData !== 16'h0 ||
            pixelValid !== 1'b0 || underflow !== 1'b0 || fifoLevel !== 5'd0) begin
            errors++;
            $display("FAIL reset_state got read=%b addr=%h pix=%h vld=%b uf=%b lvl=%0d want all zero/base",
                     bus.read, bus.readAddress, pixelData, pixelValid, underflow, fifoLevel);
        end
        m_q.delete();
        m_addr = BASE;
        m_words = 0;
        m_fetching = 1'b0;
        m_pend = 1'b0;
        m_read = 1'b0;
        m_uf = 1'b0;
        m_hold = 1'b0;
        age = 0;
        rst = 1'b0;
        repeat (4) cycle(1'b0, 1'b0);
    endtask

    task automatic test_fill();
        lat = 8;
        cycle(1'b1, 1'b0);
        repeat (180) cycle(1'b0, 1'b0);
        checks++;
        if (fifoLevel !== 5'd16 || bus.read !== 1'b0) begin
            errors++;
            $display("FAIL fill_full got lvl=%0d read=%b want lvl=16 read=0", fifoLevel, bus.read);
        end
    endtask

    task automatic test_drain();
        int guard;
        for (int i = 0; i < 16; i++) begin
            cycle(1'b0, 1'b1);
            checks++;
            if (pixelValid !== 1'b1 || pixelData !== 16'(i) || underflow !== 1'b0) begin
                errors++;
                $display("FAIL drain_order got vld=%b pix=%h uf=%b want vld=1 pix=%h uf=0",
                         pixelValid, pixelData, underflow, 16'(i));
            end
            cycle(1'b0, 1'b0);
            cycle(1'b0, 1'b0);
        end
        guard = 0;
        while ((m_fetching || m_q.size() > 0) && guard < 600) begin
            cycle(1'b0, 1'b1);
            cycle(1'b0, 1'b0);
            cycle(1'b0, 1'b0);
            guard++;
        end
        checks++;
        if (guard >= 600) begin
            errors++;
            $display("FAIL drain_timeout got guard=%0d want <600", guard);
        end
        cycle(1'b0, 1'b1);
        checks++;
        if (pixelData !== 16'h0 || underflow !== 1'b1) begin
            errors++;
            $display("FAIL underflow_strobe got pix=%h uf=%b want pix=0000 uf=1", pixelData, underflow);
        end
    endtask

    task automatic test_frame_end();
        int guard;
        lat = 2;
        delivered = 0;
        cycle(1'b1, 1'b1);
        checks++;
        if (pixelValid !== 1'b1 || pixelData !== 16'h0 || underflow !== 1'b0) begin
            errors++;
            $display("FAIL flush_wins got vld=%b pix=%h uf=%b want vld=1 pix=0000 uf=0",
                     pixelValid, pixelData, underflow);
        end
        guard = 0;
        while ((m_fetching || m_q.size() > 0) && guard < 400) begin
            cycle(1'b0, 1'b1);
            guard++;
        end
        repeat (6) cycle(1'b0, 1'b0);
        checks++;
        if (delivered !== FW || bus.read !== 1'b0 || bus.readAddress !== BASE + 24'(FW)) begin
            errors++;
            $display("FAIL frame_end got pixels=%0d read=%b addr=%h want pixels=%0d read=0 addr=%h",
                     delivered, bus.read, bus.readAddress, FW, BASE + 24'(FW));
        end
    endtask

    task automatic test_restart();
        int guard;
        lat = 8;
        cycle(1'b1, 1'b0);
        guard = 0;
        while (!(bus.read && bus.readAddress == 24'h5) && guard < 200) begin
            cycle(1'b0, 1'b0);
            guard++;
        end
        repeat (3) cycle(1'b0, 1'b0);
        cycle(1'b1, 1'b0);
        guard = 0;
        while (m_pend && guard < 20) begin
            cycle(1'b0, 1'b0);
            guard++;
        end
        checks++;
        if (bus.read !== 1'b1 || bus.readAddress !== BASE || fifoLevel !== 5'd0) begin
            errors++;
            $display("FAIL restart_pending got read=%b addr=%h lvl=%0d want read=1 addr=%h lvl=0",
                     bus.read, bus.readAddress, fifoLevel, BASE);
        end
    endtask

    task automatic test_push_pop();
        int guard;
        lat = 8;
        cycle(1'b1, 1'b0);
        guard = 0;
        while (!(m_q.size() == 7 && bus.read && age >= lat) && guard < 200) begin
            cycle(1'b0, 1'b0);
            guard++;
        end
        cycle(1'b0, 1'b1);
        checks++;
        if (fifoLevel !== 5'd7) begin
            errors++;
            $display("FAIL push_pop_level got lvl=%0d want 7", fifoLevel);
        end
    endtask

`ifdef PREFETCH_WATERMARK_EN
    task automatic test_watermark();
        int  guard;
        bool_seen: begin end
        lat = 1;
        cycle(1'b1, 1'b0);
        guard = 0;
        while (fifoLevel != 5'd16 && guard < 200) begin
            cycle(1'b0, 1'b0);
            guard++;
        end
        guard = 0;
        while (!bus.read && guard < 40) begin
            cycle(1'b0, (guard % 2) == 0);
            guard++;
        end
        checks++;
        if (bus.read !== 1'b1 || fifoLevel !== 5'd8) begin
            errors++;
            $display("FAIL watermark_resume got read=%b lvl=%0d want read=1 lvl=8", bus.read, fifoLevel);
        end
    endtask
`endif

    task automatic test_random();
        bit fs, preq;
        for (int i = 0; i < 3000; i++) begin
            lat  = $urandom_range(0, 6);
            fs   = ($urandom_range(0, 149) == 0);
            preq = !fs && !m_pend && ($urandom_range(0, 2) == 0);
            cycle(fs, preq);
        end
    endtask

    initial begin
        test_reset();
        test_fill();
        test_drain();
        test_frame_end();
        test_restart();
        test_push_pop();
`ifdef PREFETCH_WATERMARK_EN
        test_watermark();
`endif
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
